fifo_pop_decoder: RTL and testbench

- Read-side (pop) companion to the FIFO push-side one-hot write decoder.
- Owns the read pointer and occupancy count for a DEPTH-entry register-array FIFO.
- Emits a one-hot per-slot drain vector that selects the entry leaving the FIFO on each accepted pop.
- Produces empty/full flags and sticky overflow/underflow error bits for the surrounding FIFO datapath.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_onehot_dec.sv | 16 +
 rtl/fifo_pop_decoder.sv | 78 +++++++
 tb/tb_fifo_pop_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer/count types and the
// pointer wrap rule used by both the push and pop sides.
package fifo_pkg;

  localparam int unsigned FIFO_DEPTH      = 4;
  localparam int unsigned FIFO_DEPTH_BITS = 2;

  typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_BITS:0]   cnt_t;

  // Explicit wrap at depth-1 so non-power-of-two depths cycle correctly.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_onehot_dec.sv
// Pointer + enable to one-hot slot vector. Only in-range slots exist, so an
// out-of-range pointer yields all zeros. Shared with the push side.
module fifo_onehot_dec #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_BITS = 2
) (
  input  logic [DEPTH_BITS-1:0] ptr,
  input  logic                  en,
  output logic [DEPTH-1:0]      vec
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign vec[g] = en && (ptr == DEPTH_BITS'(g));
  end

endmodule

// File: rtl/fifo_pop_decoder.sv
// Read side of a register-array FIFO: owns the read pointer and occupancy,
// produces the one-hot drain vector and empty/full/error flags.
module fifo_pop_decoder
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned DEPTH_BITS = FIFO_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_push,
  input  logic                  fifo_pop,
  output logic [DEPTH-1:0]      fullness_out,
  output logic [DEPTH_BITS-1:0] ptr_out,
  output logic [DEPTH_BITS:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  pop_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = DEPTH_BITS + 1;

  logic [DEPTH_BITS-1:0] ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  pop_acc, push_acc;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // Accept decisions and next-state; a push while full only fits if a pop
  // frees the slot this cycle, and a pop never falls through a same-cycle push.
  always_comb begin
    pop_acc  = fifo_pop && !empty;
    push_acc = fifo_push && (!full || pop_acc);
    ptr_d    = ptr_q;
    if (pop_acc) ptr_d = DEPTH_BITS'(next_ptr(32'(ptr_q), DEPTH));
    cnt_d = cnt_q;
    case ({push_acc, pop_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q | (fifo_push & ~push_acc);
    unf_d = unf_q | (fifo_pop & ~pop_acc);
  end

  // State registers; reset overrides any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  fifo_onehot_dec #(.DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) u_drain_dec (
    .ptr (ptr_q),
    .en  (pop_acc),
    .vec (fullness_out)
  );

  assign pop_ack   = pop_acc;
  assign ptr_out   = ptr_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_pop_decoder.sv
// Scoreboard bench: stimulus queues the hand-computed expected outputs of
// each cycle, a negedge monitor pops and compares. Two instances: DEPTH=4
// and the non-power-of-two DEPTH=3.
module tb_fifo_pop_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       p_rst = 1'b1, p_push = 1'b0, p_pop = 1'b0;
  logic [3:0] p_fo;
  logic [1:0] p_ptr;
  logic [2:0] p_cnt;
  logic       p_empty, p_full, p_ack, p_ovf, p_unf;

  logic       q_rst = 1'b1, q_push = 1'b0, q_pop = 1'b0;
  logic [2:0] q_fo;
  logic [1:0] q_ptr;
  logic [2:0] q_cnt;
  logic       q_empty, q_full, q_ack, q_ovf, q_unf;

  fifo_pop_decoder #(.DEPTH(4), .DEPTH_BITS(2)) dut (
    .clk(clk), .rst(p_rst), .fifo_push(p_push), .fifo_pop(p_pop),
    .fullness_out(p_fo), .ptr_out(p_ptr), .count(p_cnt), .empty(p_empty),
    .full(p_full), .pop_ack(p_ack), .overflow(p_ovf), .underflow(p_unf)
  );

  fifo_pop_decoder #(.DEPTH(3), .DEPTH_BITS(2)) dut3 (
    .clk(clk), .rst(q_rst), .fifo_push(q_push), .fifo_pop(q_pop),
    .fullness_out(q_fo), .ptr_out(q_ptr), .count(q_cnt), .empty(q_empty),
    .full(q_full), .pop_ack(q_ack), .overflow(q_ovf), .underflow(q_unf)
  );

  typedef struct {
    bit sel;
    int ptr;
    int cnt;
    bit ack;
    int fo;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  task automatic chk(input string name, input int step, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected instance and queue what its
  // outputs must show during that cycle.
  task automatic step(input bit sel, input bit r, input bit pu, input bit po,
                      input int e_ptr, input int e_cnt, input bit e_ack,
                      input int e_fo, input bit e_ovf, input bit e_unf);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      p_rst = r; p_push = pu; p_pop = po;
      q_rst = 1'b0; q_push = 1'b0; q_pop = 1'b0;
    end else begin
      q_rst = r; q_push = pu; q_pop = po;
      p_rst = 1'b0; p_push = 1'b0; p_pop = 1'b0;
    end
    e.sel = sel; e.ptr = e_ptr; e.cnt = e_cnt; e.ack = e_ack;
    e.fo = e_fo; e.ovf = e_ovf; e.unf = e_unf;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the selected instance.
  initial begin
    exp_t e;
    int   depth;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_step++;
        depth = e.sel ? 3 : 4;
        if (!e.sel) begin
          chk("d4.ptr_out", n_step, int'(p_ptr), e.ptr);
          chk("d4.count", n_step, int'(p_cnt), e.cnt);
          chk("d4.empty", n_step, int'(p_empty), int'(e.cnt == 0));
          chk("d4.full", n_step, int'(p_full), int'(e.cnt == depth));
          chk("d4.pop_ack", n_step, int'(p_ack), int'(e.ack));
          chk("d4.fullness_out", n_step, int'(p_fo), e.fo);
          chk("d4.onehot0", n_step, int'($onehot0(p_fo)), 1);
          chk("d4.overflow", n_step, int'(p_ovf), int'(e.ovf));
          chk("d4.underflow", n_step, int'(p_unf), int'(e.unf));
        end else begin
          chk("d3.ptr_out", n_step, int'(q_ptr), e.ptr);
          chk("d3.count", n_step, int'(q_cnt), e.cnt);
          chk("d3.empty", n_step, int'(q_empty), int'(e.cnt == 0));
          chk("d3.full", n_step, int'(q_full), int'(e.cnt == depth));
          chk("d3.pop_ack", n_step, int'(q_ack), int'(e.ack));
          chk("d3.fullness_out", n_step, int'(q_fo), e.fo);
          chk("d3.overflow", n_step, int'(q_ovf), int'(e.ovf));
          chk("d3.underflow", n_step, int'(q_unf), int'(e.unf));
        end
      end
    end
  end

  initial begin
    int budget;
    //    sel rst psh pop  ptr cnt ack fo    ovf unf
    // reset, then pop while empty
    step(0, 1, 0, 0,   0,  0, 0, 4'b0000, 0, 0);
    step(0, 0, 0, 1,   0,  0, 0, 4'b0000, 0, 0);
    // 3 pushes then 3 pops
    step(0, 0, 1, 0,   0,  0, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   0,  1, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   0,  2, 0, 4'b0000, 0, 1);
    step(0, 0, 0, 1,   0,  3, 1, 4'b0001, 0, 1);
    step(0, 0, 0, 1,   1,  2, 1, 4'b0010, 0, 1);
    step(0, 0, 0, 1,   2,  1, 1, 4'b0100, 0, 1);
    step(0, 0, 0, 0,   3,  0, 0, 4'b0000, 0, 1);
    // fill to 4, push+pop while full, then push alone while full
    step(0, 0, 1, 0,   3,  0, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   3,  1, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   3,  2, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   3,  3, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 1,   3,  4, 1, 4'b1000, 0, 1);
    step(0, 0, 1, 0,   0,  4, 0, 4'b0000, 0, 1);
    step(0, 0, 0, 0,   0,  4, 0, 4'b0000, 1, 1);
    // drain
    step(0, 0, 0, 1,   0,  4, 1, 4'b0001, 1, 1);
    step(0, 0, 0, 1,   1,  3, 1, 4'b0010, 1, 1);
    step(0, 0, 0, 1,   2,  2, 1, 4'b0100, 1, 1);
    step(0, 0, 0, 1,   3,  1, 1, 4'b1000, 1, 1);
    step(0, 0, 0, 0,   0,  0, 0, 4'b0000, 1, 1);
    // wrap: 8 push/pop pairs
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 0, k % 4, 0, 0, 4'b0000, 1, 1);
      step(0, 0, 0, 1, k % 4, 1, 1, 1 << (k % 4), 1, 1);
    end
    // reset, then push+pop while empty: pop rejected, push lands
    step(0, 1, 0, 0,   0,  0, 0, 4'b0000, 1, 1);
    step(0, 0, 1, 1,   0,  0, 0, 4'b0000, 0, 0);
    step(0, 0, 0, 0,   0,  1, 0, 4'b0000, 0, 1);
    // reach count=3, ptr=2, then reset with push+pop high
    step(0, 0, 0, 1,   0,  1, 1, 4'b0001, 0, 1);
    step(0, 0, 1, 0,   1,  0, 0, 4'b0000, 0, 1);
    step(0, 0, 0, 1,   1,  1, 1, 4'b0010, 0, 1);
    step(0, 0, 1, 0,   2,  0, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   2,  1, 0, 4'b0000, 0, 1);
    step(0, 0, 1, 0,   2,  2, 0, 4'b0000, 0, 1);
    step(0, 1, 1, 1,   2,  3, 1, 4'b0100, 0, 1);
    step(0, 0, 0, 0,   0,  0, 0, 4'b0000, 0, 0);
    // DEPTH=3 instance: fill, full, pointer wrap 0,1,2,0
    step(1, 1, 0, 0,   0,  0, 0, 3'b000, 0, 0);
    step(1, 0, 1, 0,   0,  0, 0, 3'b000, 0, 0);
    step(1, 0, 1, 0,   0,  1, 0, 3'b000, 0, 0);
    step(1, 0, 1, 0,   0,  2, 0, 3'b000, 0, 0);
    step(1, 0, 0, 0,   0,  3, 0, 3'b000, 0, 0);
    step(1, 0, 0, 1,   0,  3, 1, 3'b001, 0, 0);
    step(1, 0, 1, 1,   1,  2, 1, 3'b010, 0, 0);
    step(1, 0, 0, 1,   2,  2, 1, 3'b100, 0, 0);
    step(1, 0, 0, 1,   0,  1, 1, 3'b001, 0, 0);
    step(1, 0, 0, 0,   1,  0, 0, 3'b000, 0, 0);

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
